// File: rtl/ycbcr422_sequencer.sv
// rtl/ycbcr422_sequencer.sv - 4:2:2 Cb/Y/Cr/Y to per-pixel YCbCr triplets with latency-matched sideband
// Optional x-coordinate counter enabled by defining SEQ_XPOS_EN.
module ycbcr422_sequencer #(
   parameter int LAT = 3,
   parameter int XW  = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [9:0]    din,
   input  logic          din_valid,
   input  logic          din_sol,
   input  logic          err_clr,
   output logic [9:0]    y_out,
   output logic [9:0]    cb_out,
   output logic [9:0]    cr_out,
   output logic          conv_valid,
   output logic          rgb_valid,
   output logic          rgb_sol,
   output logic [XW-1:0] x_pos,
   output logic          sync_err
);

   typedef enum logic [1:0] {S_CB, S_Y0, S_CR, S_Y1} state_t;

   state_t         state;
   logic [9:0]     cb_hold;
   logic [9:0]     y0_hold;
   logic [9:0]     cr_hold;
   logic           sol_pend;
   logic           conv_sol;
   logic [LAT-1:0] dv_q;
   logic [LAT-1:0] ds_q;
   logic [LAT-1:0] dv_next;
   logic [LAT-1:0] ds_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_CB;
         cb_hold    <= '0;
         y0_hold    <= '0;
         cr_hold    <= '0;
         sol_pend   <= 1'b0;
         y_out      <= '0;
         cb_out     <= '0;
         cr_out     <= '0;
         conv_valid <= 1'b0;
         conv_sol   <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         conv_valid <= 1'b0;
         conv_sol   <= 1'b0;
         if (din_valid && din_sol) begin
            // A line start always restarts the pair; any partial pair is dropped.
            cb_hold  <= din;
            sol_pend <= 1'b1;
            state    <= S_Y0;
         end else if (din_valid) begin
            case (state)
               S_CB: begin
                  cb_hold  <= din;
                  sol_pend <= 1'b0;
                  state    <= S_Y0;
               end
               S_Y0: begin
                  y0_hold <= din;
                  state   <= S_CR;
               end
               S_CR: begin
                  cr_hold    <= din;
                  y_out      <= y0_hold;
                  cb_out     <= cb_hold;
                  cr_out     <= din;
                  conv_valid <= 1'b1;
                  conv_sol   <= sol_pend;
                  sol_pend   <= 1'b0;
                  state      <= S_Y1;
               end
               S_Y1: begin
                  y_out      <= din;
                  cb_out     <= cb_hold;
                  cr_out     <= cr_hold;
                  conv_valid <= 1'b1;
                  state      <= S_CB;
               end
               default: state <= S_CB;
            endcase
         end

         // A new error takes priority over a simultaneous clear.
         if (din_valid && din_sol && (state != S_CB))
            sync_err <= 1'b1;
         else if (err_clr)
            sync_err <= 1'b0;
      end
   end

   always_comb begin
      dv_next = LAT'({dv_q, conv_valid});
      ds_next = LAT'({ds_q, conv_sol});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dv_q <= '0;
         ds_q <= '0;
      end else begin
         dv_q <= dv_next;
         ds_q <= ds_next;
      end
   end

   assign rgb_valid = dv_q[LAT-1];
   assign rgb_sol   = ds_q[LAT-1];

`ifdef SEQ_XPOS_EN
   localparam logic [XW-1:0] X_MAX = '1;

   // Loaded from the stage feeding the tail so x_pos is valid alongside rgb_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_pos <= '0;
      end else if (dv_next[LAT-1]) begin
         if (ds_next[LAT-1])
            x_pos <= '0;
         else if (x_pos != X_MAX)
            x_pos <= x_pos + XW'(1);
      end
   end
`else
   assign x_pos = '0;
`endif

endmodule
